// File: rtl/key_token_queue.sv
// Key press qualifier and token FIFO. A key must stay down for STABLE_CYC
// cycles before its calculator token is queued; nothing more is accepted until it releases.
module key_token_queue #(
    parameter int SCAN_W     = 9,
    parameter int OH_W       = 512,
    parameter int STABLE_CYC = 100000,
    parameter int DEPTH      = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [OH_W-1:0]        key_down,
    input  logic [SCAN_W-1:0]      last_change,
    input  logic                   key_valid,
    input  logic                   tok_ready,
    output logic                   tok_valid,
    output logic [3:0]             tok_data,
    output logic [$clog2(DEPTH):0] tok_count,
    output logic [SCAN_W-1:0]      held_code,
    output logic                   overflow
);
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = PW + 1;
    localparam int CNT_W = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
    localparam logic [3:0] NO_TOK = 4'hF;

    typedef enum logic [1:0] {IDLE, QUAL, PUSH, WAIT_REL} state_t;

    // 0xF is never a real token, so it doubles as the "unmapped" marker.
    function automatic logic [3:0] map_tok(input logic [SCAN_W-1:0] code);
        logic [15:0] c;
        c = 16'(code);
        case (c)
            16'h045, 16'h070: map_tok = 4'h0;
            16'h016, 16'h069: map_tok = 4'h1;
            16'h01E, 16'h072: map_tok = 4'h2;
            16'h026, 16'h07A: map_tok = 4'h3;
            16'h025, 16'h06B: map_tok = 4'h4;
            16'h02E, 16'h073: map_tok = 4'h5;
            16'h036, 16'h074: map_tok = 4'h6;
            16'h03D, 16'h06C: map_tok = 4'h7;
            16'h03E, 16'h075: map_tok = 4'h8;
            16'h046, 16'h07D: map_tok = 4'h9;
            16'h05A, 16'h15A: map_tok = 4'hA;
            16'h079:          map_tok = 4'hB;
            16'h04E, 16'h07B: map_tok = 4'hC;
            16'h07C:          map_tok = 4'hD;
            16'h066:          map_tok = 4'hE;
            default:          map_tok = NO_TOK;
        endcase
    endfunction

    state_t              state_q, state_d;
    logic [SCAN_W-1:0]   held_q, held_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                push;

    logic                held_down, new_make;
    logic [3:0]          held_tok;

    assign held_down = key_down[held_q];
    assign held_tok  = map_tok(held_q);
    assign new_make  = key_valid && key_down[last_change] && (map_tok(last_change) != NO_TOK);

    always_comb begin
        state_d = state_q;
        held_d  = held_q;
        cnt_d   = cnt_q;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (new_make) begin
                    held_d  = last_change;
                    cnt_d   = '0;
                    state_d = QUAL;
                end
            end
            QUAL: begin
                // Release wins over both a re-latch and the final count.
                if (!held_down) begin
                    held_d  = '0;
                    state_d = IDLE;
                end else if (new_make && last_change != held_q) begin
                    held_d = last_change;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_W'(STABLE_CYC - 1)) begin
                    state_d = PUSH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PUSH: begin
                push    = 1'b1;
                state_d = WAIT_REL;
            end
            WAIT_REL: begin
                if (!held_down) begin
                    held_d  = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            held_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
            cnt_q   <= cnt_d;
        end
    end

    logic [3:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [CW-1:0] count_q;
    logic          ovf_q;
    logic          pop, full, wr_en;

    assign pop   = tok_valid && tok_ready;
    assign full  = (count_q == CW'(DEPTH));
    // A pop in the same cycle frees the head slot, so a full FIFO still accepts.
    assign wr_en = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q] <= held_tok;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (wr_en) wr_q <= wr_q + PW'(1);
            if (pop)   rd_q <= rd_q + PW'(1);
            count_q <= count_q + CW'(wr_en) - CW'(pop);
            if (push && !wr_en) ovf_q <= 1'b1;
        end
    end

    assign tok_valid = (count_q != '0);
    assign tok_data  = tok_valid ? mem_q[rd_q] : 4'h0;
    assign tok_count = count_q;
    assign held_code = held_q;
    assign overflow  = ovf_q;

endmodule
